// File: rtl/lane_strobe_pkg.sv
// Shared types and helpers for the lane strobe decoder and its hold timer.
// Holds the two-state controller encoding and a width helper for counters.
package lane_strobe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } stateT;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >>> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/lane_strobe_decoder_hold_counter.sv
// Loadable down-counter that flags the last counted cycle.
// Stops at zero so an idle counter never wraps.
module hold_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             dec,
    output logic             terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == CNT_W'(1));

endmodule

// File: rtl/lane_strobe_decoder.sv
// Decodes a lane index into a one-hot strobe held for HOLD_CYCLES cycles,
// with optional retrigger and active-low output polarity.
module lane_strobe_decoder
    import lane_strobe_pkg::*;
#(
    parameter int SEL_W       = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int RETRIGGER   = 1,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 sel_valid,
    output logic                 ready,
    output logic [2**SEL_W-1:0]  onehot,
    output logic                 busy,
    output logic                 done
);

    localparam int LANES = 2 ** SEL_W;
    localparam int CNT_W = clog2(HOLD_CYCLES + 1);
    localparam logic [LANES-1:0] IDLE_PATTERN = {LANES{ACTIVE_LOW != 0}};

    // Polarity is folded in here so onehot leaves straight from a flop.
    function automatic logic [LANES-1:0] laneCode(input logic [SEL_W-1:0] lane);
        logic [LANES-1:0] one;
        one = {{(LANES-1){1'b0}}, 1'b1};
        return (one << lane) ^ IDLE_PATTERN;
    endfunction

    stateT state;
    stateT stateNext;
    logic  accept;
    logic  lastCycle;
    logic  finishing;

    assign ready  = en && ((state == IDLE) || (RETRIGGER != 0));
    assign accept = sel_valid && ready;

    hold_counter #(
        .CNT_W(CNT_W)
    ) holdTimer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .loadValue(CNT_W'(HOLD_CYCLES)),
        .dec      (state == HOLD),
        .terminal (lastCycle)
    );

    always_comb begin
        stateNext = state;
        finishing = 1'b0;
        case (state)
            IDLE: begin
                if (accept) stateNext = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    stateNext = HOLD;
                end else if (lastCycle) begin
                    stateNext = IDLE;
                    finishing = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // A retrigger overrides expiry, so an aborted hold never reports done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            onehot <= IDLE_PATTERN;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= stateNext;
            busy  <= (stateNext == HOLD);
            done  <= finishing;
            if (accept) begin
                onehot <= laneCode(sel);
            end else if (finishing) begin
                onehot <= IDLE_PATTERN;
            end
        end
    end

endmodule

// File: tb/tb_lane_strobe_decoder.sv
// Drives three decoder configurations with shared stimulus and compares each
// against a cycle-level model built from remaining-hold counts.
module tb_lane_strobe_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       selValid;
    logic [2:0] sel;

    logic       readyA, busyA, doneA;
    logic       readyB, busyB, doneB;
    logic       readyC, busyC, doneC;
    logic [3:0] onehotA, onehotB;
    logic [7:0] onehotC;

    always #5 clk = ~clk;

    lane_strobe_decoder #(.SEL_W(2), .HOLD_CYCLES(4), .RETRIGGER(1), .ACTIVE_LOW(0)) dutA (
        .clk(clk), .rst(rst), .en(en), .sel(sel[1:0]), .sel_valid(selValid),
        .ready(readyA), .onehot(onehotA), .busy(busyA), .done(doneA));

    lane_strobe_decoder #(.SEL_W(2), .HOLD_CYCLES(4), .RETRIGGER(0), .ACTIVE_LOW(0)) dutB (
        .clk(clk), .rst(rst), .en(en), .sel(sel[1:0]), .sel_valid(selValid),
        .ready(readyB), .onehot(onehotB), .busy(busyB), .done(doneB));

    lane_strobe_decoder #(.SEL_W(3), .HOLD_CYCLES(1), .RETRIGGER(1), .ACTIVE_LOW(1)) dutC (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .sel_valid(selValid),
        .ready(readyC), .onehot(onehotC), .busy(busyC), .done(doneC));

    // Model configuration per instance: hold length, retrigger, polarity, lanes.
    int holdLen[3]   = '{4, 4, 1};
    int retrig[3]    = '{1, 0, 1};
    int activeLow[3] = '{0, 0, 1};
    int lanes[3]     = '{4, 4, 8};

    // Model state: cycles of strobe still to show, latched lane, done pulse.
    int remain[3];
    int lane[3];
    int doneExp[3];

    int checks = 0;
    int passes = 0;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] expReady(input int i);
        return {31'd0, en && ((remain[i] == 0) || (retrig[i] != 0))};
    endfunction

    function automatic logic [31:0] expOnehot(input int i);
        logic [31:0] mask;
        logic [31:0] code;
        mask = (32'd1 << lanes[i]) - 32'd1;
        code = (remain[i] > 0) ? (32'd1 << lane[i]) : 32'd0;
        if (activeLow[i] != 0) code = ~code;
        return code & mask;
    endfunction

    function automatic logic [31:0] dutOnehot(input int i);
        case (i)
            0:       return {28'd0, onehotA};
            1:       return {28'd0, onehotB};
            default: return {24'd0, onehotC};
        endcase
    endfunction

    function automatic logic [31:0] dutReady(input int i);
        case (i)
            0:       return {31'd0, readyA};
            1:       return {31'd0, readyB};
            default: return {31'd0, readyC};
        endcase
    endfunction

    function automatic logic [31:0] dutBusy(input int i);
        case (i)
            0:       return {31'd0, busyA};
            1:       return {31'd0, busyB};
            default: return {31'd0, busyC};
        endcase
    endfunction

    function automatic logic [31:0] dutDone(input int i);
        case (i)
            0:       return {31'd0, doneA};
            1:       return {31'd0, doneB};
            default: return {31'd0, doneC};
        endcase
    endfunction

    // One clock: apply inputs, check ready, advance model at the edge, check outputs.
    task automatic cycle(input logic r, input logic e, input logic v, input logic [2:0] s);
        int accepted[3];
        rst = r; en = e; selValid = v; sel = s;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkValue($sformatf("ready%0d", i), dutReady(i), expReady(i));
            accepted[i] = (v && expReady(i) != 0) ? 1 : 0;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                remain[i] = 0; lane[i] = 0; doneExp[i] = 0;
            end else if (accepted[i] != 0) begin
                remain[i] = holdLen[i];
                lane[i]   = int'(s) % lanes[i];
                doneExp[i] = 0;
            end else if (remain[i] > 0) begin
                remain[i]--;
                doneExp[i] = (remain[i] == 0) ? 1 : 0;
            end else begin
                doneExp[i] = 0;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            checkValue($sformatf("onehot%0d", i), dutOnehot(i), expOnehot(i));
            checkValue($sformatf("busy%0d", i), dutBusy(i), {31'd0, remain[i] > 0});
            checkValue($sformatf("done%0d", i), dutDone(i), doneExp[i][31:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b0, 3'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            remain[i] = 0; lane[i] = 0; doneExp[i] = 0;
        end
        rst = 1'b1; en = 1'b0; selValid = 1'b0; sel = 3'd0;

        cycle(1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 1'b1, 3'd5);
        idle(2);

        // Single request, lane 2.
        cycle(1'b0, 1'b1, 1'b1, 3'd2);
        idle(6);

        // Lane 1 then lane 3 two cycles later.
        cycle(1'b0, 1'b1, 1'b1, 3'd1);
        idle(1);
        cycle(1'b0, 1'b1, 1'b1, 3'd3);
        idle(6);

        // Lane 0, then lane 3 repeatedly requested through the hold.
        cycle(1'b0, 1'b1, 1'b1, 3'd0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1, 3'd3);
        idle(6);

        // Reset lands on the second hold cycle together with a request.
        cycle(1'b0, 1'b1, 1'b1, 3'd2);
        idle(1);
        cycle(1'b1, 1'b1, 1'b1, 3'd1);
        idle(5);

        // Lane 7 requested on three consecutive cycles.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 3'd7);
        idle(3);

        // Enable low blocks requests; dropping it mid-hold lets the hold finish.
        cycle(1'b0, 1'b0, 1'b1, 3'd2);
        cycle(1'b0, 1'b0, 1'b1, 3'd3);
        cycle(1'b0, 1'b1, 1'b1, 3'd1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, k[0], 3'd2);
        idle(2);

        // Random traffic, including back-to-back and final-cycle requests.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 2) != 0),
                  3'($urandom_range(0, 7)));
        end
        idle(6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lane_strobe_decoder.md
LANE_STROBE_DECODER -- requirements
Module: lane_strobe_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 2, meaning select width; decoded output width is 2**SEL_W; legal range 1..5.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning cycles each accepted strobe stays asserted; legal range 1..65535.
REQ-003 SHALL have parameter RETRIGGER, default 1, meaning 1 = a new request during hold restarts the hold, 0 = such a request is refused.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0, meaning 1 = onehot output inverted (idle all-ones).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port en  input  1  global enable; low = no new request accepted, current hold continues.
REQ-008 SHALL have port sel  input  SEL_W  lane index to decode.
REQ-009 SHALL have port sel_valid  input  1  request strobe qualifying sel.
REQ-010 SHALL have port ready  output  1  combinational: en AND (state==IDLE OR RETRIGGER==1).
REQ-011 SHALL have port onehot  output  2**SEL_W  registered decoded lane, bit sel set while holding.
REQ-012 SHALL have port busy  output  1  registered, high while state==HOLD.
REQ-013 SHALL have port done  output  1  registered one-cycle pulse when a hold expires naturally.

Function
REQ-014 SHALL accept a request in a cycle where sel_valid AND ready are both high; no other cycle changes the latched lane.
REQ-015 SHALL use two states, IDLE and HOLD; IDLE->HOLD on accept; HOLD->IDLE when hold counter reaches 1 with no accept; HOLD->HOLD on accept (RETRIGGER=1 only).
REQ-016 SHALL, on accept in cycle t, assert onehot bit sel (all others clear) from cycle t+1 through t+HOLD_CYCLES inclusive, one-cycle latency.
REQ-017 SHALL load hold counter with HOLD_CYCLES on accept and decrement once per cycle in HOLD; counter width clog2(HOLD_CYCLES+1).
REQ-018 SHALL, on natural expiry, clear onehot and pulse done in cycle t+HOLD_CYCLES+1, and deassert busy that same cycle.
REQ-019 SHALL, with RETRIGGER=1 and accept during HOLD (including the final hold cycle), switch onehot to the new lane next cycle, reload the counter, and not pulse done for the aborted hold.
REQ-020 SHALL, with RETRIGGER=0, ignore sel_valid throughout HOLD including the final hold cycle; a request is first acceptable in the cycle busy is low.
REQ-021 SHALL with HOLD_CYCLES=1 assert onehot exactly one cycle per accept; back-to-back accepts with RETRIGGER=1 yield continuous onehot with no done until the last.
REQ-022 SHALL keep onehot exactly one-hot in HOLD and all-zero in IDLE (before ACTIVE_LOW inversion); all sel values are legal.
REQ-023 SHALL let en=0 block new accepts only; an active hold runs to completion and pulses done.

Reset
REQ-024 SHALL, on rst high at a rising edge, force state IDLE, counter 0, onehot all-zero (all-ones if ACTIVE_LOW=1), busy 0, done 0, regardless of state.
REQ-025 SHALL give rst priority over a simultaneous accept; the request is lost and no done pulse is produced for a hold cut short by reset.

Structure
REQ-026 SHALL place the state typedef (IDLE, HOLD) and a clog2 constant function in shared package lane_strobe_pkg.
REQ-027 SHALL instantiate one sub-module, hold_counter (loadable down-counter with terminal-count flag, parametrised width), for the hold timer.
REQ-028 SHALL implement the decode as a registered shift-of-one, not per-bit gate instances.

Verification
REQ-029 SHALL cover basic: SEL_W=2, HOLD=4, sel=2 valid one cycle -> onehot=4'b0100 for exactly 4 cycles, done pulse on 5th, busy high 4 cycles.
REQ-030 SHALL cover retrigger: RETRIGGER=1, sel=1 then sel=3 two cycles later -> onehot 0010 for 2 cycles, then 1000 for 4 cycles, single done.
REQ-031 SHALL cover refusal: RETRIGGER=0, sel=0 then sel=3 during hold -> ready low, onehot 0001 for 4 cycles, sel=3 never appears.
REQ-032 SHALL cover reset mid-hold: rst at hold cycle 2 with sel_valid high -> next cycle onehot=0, busy=0, done=0, request dropped.
REQ-033 SHALL cover width/edge: SEL_W=3, HOLD=1, ACTIVE_LOW=1, sel=7 valid 3 consecutive cycles -> onehot=8'b01111111 for 3 cycles, one done after.
REQ-034 SHALL cover enable: en=0 with sel_valid high -> ready low, no change; en dropped mid-hold -> hold completes, done pulses.
